ttt_win_detector: RTL and testbench
===================================

Name: ttt_win_detector

Overview:
Game-state and win-detection stage for the 3-in-a-row game. It sits directly upstream of the RGB LED driver and feeds it `detect_win[1:0]`.
- Accepts player moves through a valid/ready handshake and stores both players' boards.
- After each legal move it scans the 8 winning lines sequentially, one line per cycle.
- Reports player-1 win, player-2 win or draw, and holds the result until a new game starts.

Parameters:
FIRST_PLAYER, 1'b0, player who moves first after reset/new_game (0 = player 1, 1 = player 2).

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
new_game  input  1  synchronous clear of board/result. Lower priority than reset, higher priority than moves.
move_valid  input  1  move request.
move_pos  input  4  cell index, row-major. 0 = top-left, 8 = bottom-right. 9..15 are illegal.
move_ready  output  1  high only in IDLE; handshake occurs when move_valid && move_ready.
move_err  output  1  one-cycle pulse for an illegal move.
turn  output  1  player to move (0 = P1, 1 = P2).
board_p1  output  9  P1-occupied cells, bit i = cell i.
board_p2  output  9  P2-occupied cells.
busy  output  1  high in CHECK.
detect_win  output  2  00 = in play, 01 = P1 wins, 10 = P2 wins, 11 = draw. Registered.

Behaviour:
- Reset values:
  - board_p1 = board_p2 = 0
  - move count = 0
  - turn = FIRST_PLAYER
  - detect_win = 00
  - move_err = 0
  - state = IDLE (move_ready = 1, busy = 0)
- new_game: same effect as reset from any state, including aborting a CHECK. Asserting it together with a handshake discards the move.
- Handshake while move_pos > 8 or the cell is occupied in either board:
  - move_err = 1 on the following cycle only.
  - Board, turn and count are unchanged; state stays IDLE.
- Handshake with a legal move at edge T:
  - The mover's board bit is set and the count is incremented.
  - State goes to CHECK with line index 0, and the mover is latched.
- CHECK: one line per cycle, evaluated against the mover's board only. Line order by index 0..7:
  - idx 0–2: rows {0,1,2}, {3,4,5}, {6,7,8}
  - idx 3–5: columns {0,3,6}, {1,4,7}, {2,5,8}
  - idx 6–7: diagonals {0,4,8}, {2,4,6}
- Line idx k is decided at edge T+1+k:
  - Match: detect_win = 01 (mover P1) or 10 (mover P2); state goes to DONE. Remaining lines are skipped.
  - No match and k < 7: idx is incremented.
  - No match and k = 7, count = 9: detect_win = 11; state goes to DONE.
  - No match and k = 7, count < 9: turn toggles; state goes to IDLE. move_ready is high from T+8.
- A win on the 9th move reports the win, not a draw.
- move_valid in CHECK or DONE is ignored: move_ready = 0, no move_err.
- DONE:
  - detect_win and both boards hold; move_ready = 0.
  - Exit only via reset or new_game.
- Worst-case latency from accepted move to result or ready is 8 cycles.
- Reset or new_game in mid-CHECK: the next cycle shows reset values. The pending move is lost along with the board.

Test Plan:
- Reset, then P1 top row. Moves 0, 3, 1, 4, 2 (each issued when move_ready):
  - After the 5th handshake at T, detect_win = 01 at T+1; board_p1 = 9'b000000111.
  - A subsequent move_valid is ignored and move_ready stays 0.
- P2 anti-diagonal. Moves 0, 2, 1, 4, 3, 6:
  - Idx 6 does not match and idx 7 matches, so detect_win = 10 at T+8; board_p2 = 9'b001010100.
- Draw. Moves 0, 1, 2, 4, 3, 5, 7, 6, 8:
  - detect_win stays 00 throughout and becomes 11 at T+8 after the 9th handshake.
- Illegal moves:
  - After move 4, a move to 4 gives a move_err pulse, and board, turn and count are unchanged.
  - move_pos = 9 and move_pos = 15 each give a one-cycle move_err.
  - A following move to 5 is accepted.
- Mid-check reset:
  - Assert reset at T+3 after a legal move: next cycle all outputs are at reset values and move_ready = 1.
  - Repeat with new_game instead of reset, and with new_game in DONE: detect_win returns to 00 and turn = FIRST_PLAYER.
- Busy/ready timing for a non-terminal move:
  - busy is high T+1..T+8 and move_ready is low in the same window.
  - turn toggles at T+8; a move_valid held high throughout is accepted at the first edge ≥ T+8.

Source files
------------

// File: rtl/ttt_win_detector_if.sv
// rtl/ttt_win_detector_if.sv - move handshake and game-status bundle for the win detector
// Purpose: groups the move request/handshake, new-game control and game status signals.
// Signals:
//   new_game   : synchronous clear of board and result (driven by the master)
//   move_valid : move request (master)
//   move_pos   : cell index 0..8, row-major; 9..15 illegal (master)
//   move_ready : high only while the detector can accept a move (slave)
//   move_err   : one-cycle pulse after an illegal move (slave)
//   turn       : player to move, 0 = P1, 1 = P2 (slave)
//   board_p1   : P1-occupied cells, bit i = cell i (slave)
//   board_p2   : P2-occupied cells (slave)
//   busy       : high while lines are being scanned (slave)
//   detect_win : 00 in play, 01 P1 wins, 10 P2 wins, 11 draw (slave)
interface ttt_win_detector_if;
    logic       new_game;
    logic       move_valid;
    logic [3:0] move_pos;
    logic       move_ready;
    logic       move_err;
    logic       turn;
    logic [8:0] board_p1;
    logic [8:0] board_p2;
    logic       busy;
    logic [1:0] detect_win;

    modport master (
        output new_game, move_valid, move_pos,
        input  move_ready, move_err, turn, board_p1, board_p2, busy, detect_win
    );

    modport slave (
        input  new_game, move_valid, move_pos,
        output move_ready, move_err, turn, board_p1, board_p2, busy, detect_win
    );
endinterface

// File: rtl/ttt_win_detector.sv
// rtl/ttt_win_detector.sv - game state and sequential 3-in-a-row win detection
// Purpose: accepts moves, keeps both boards, scans the 8 winning lines one per
// cycle after every legal move, and holds the win/draw result until a new game.
// Ports:
//   clk   : system clock, posedge
//   reset : synchronous, active-high reset
//   bus   : slave side of ttt_win_detector_if (moves in, game status out)
module ttt_win_detector #(
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    ttt_win_detector_if.slave         bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t     state_q;
    logic [8:0] board_p1_q;
    logic [8:0] board_p2_q;
    logic [3:0] count_q;
    logic       turn_q;
    logic       mover_q;
    logic [2:0] idx_q;
    logic [1:0] win_q;
    logic       err_q;

    logic [8:0] cell_bit;
    logic       move_legal;
    logic [8:0] line_mask;
    logic [8:0] mover_board;
    logic       line_hit;

    // For positions above 8 the shifted bit falls off the 9-bit vector, so the
    // range test below is what actually rejects them.
    assign cell_bit   = 9'd1 << bus.move_pos;
    assign move_legal = (bus.move_pos <= 4'd8) &&
                        (((board_p1_q | board_p2_q) & cell_bit) == 9'd0);

    always_comb begin
        line_mask = 9'b000000111;
        case (idx_q)
            3'd0: line_mask = 9'b000000111;
            3'd1: line_mask = 9'b000111000;
            3'd2: line_mask = 9'b111000000;
            3'd3: line_mask = 9'b001001001;
            3'd4: line_mask = 9'b010010010;
            3'd5: line_mask = 9'b100100100;
            3'd6: line_mask = 9'b100010001;
            3'd7: line_mask = 9'b001010100;
            default: line_mask = 9'b000000111;
        endcase
    end

    // Only the player who just moved can have completed a line.
    assign mover_board = mover_q ? board_p2_q : board_p1_q;
    assign line_hit    = (mover_board & line_mask) == line_mask;

    always_ff @(posedge clk) begin
        if (reset || bus.new_game) begin
            state_q    <= S_IDLE;
            board_p1_q <= 9'd0;
            board_p2_q <= 9'd0;
            count_q    <= 4'd0;
            turn_q     <= FIRST_PLAYER;
            mover_q    <= FIRST_PLAYER;
            idx_q      <= 3'd0;
            win_q      <= 2'b00;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.move_valid) begin
                        if (move_legal) begin
                            if (turn_q) begin
                                board_p2_q <= board_p2_q | cell_bit;
                            end else begin
                                board_p1_q <= board_p1_q | cell_bit;
                            end
                            count_q <= count_q + 4'd1;
                            mover_q <= turn_q;
                            idx_q   <= 3'd0;
                            state_q <= S_CHECK;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (line_hit) begin
                        win_q   <= mover_q ? 2'b10 : 2'b01;
                        state_q <= S_DONE;
                    end else if (idx_q != 3'd7) begin
                        idx_q <= idx_q + 3'd1;
                    end else if (count_q == 4'd9) begin
                        // A win on the last move is caught above, so this is a draw.
                        win_q   <= 2'b11;
                        state_q <= S_DONE;
                    end else begin
                        turn_q  <= ~turn_q;
                        state_q <= S_IDLE;
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.move_ready = (state_q == S_IDLE);
    assign bus.busy       = (state_q == S_CHECK);
    assign bus.move_err   = err_q;
    assign bus.turn       = turn_q;
    assign bus.board_p1   = board_p1_q;
    assign bus.board_p2   = board_p2_q;
    assign bus.detect_win = win_q;

endmodule

// File: tb/tb_ttt_win_detector.sv
// tb/tb_ttt_win_detector.sv - self-checking bench for ttt_win_detector
module tb_ttt_win_detector;

    localparam logic FIRST_PLAYER = 1'b0;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    ttt_win_detector_if bus ();

    ttt_win_detector #(.FIRST_PLAYER(FIRST_PLAYER)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: cells hold 0 (empty), 1 (P1) or 2 (P2). On each accepted move
    // the outcome is computed at once by searching the line list; only the delay
    // until it becomes visible is counted down cycle by cycle.
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    int   m_cell [9];
    int   m_count;
    int   m_turn;
    int   m_win;
    int   m_err;
    int   m_phase;      // 0 idle, 1 scanning, 2 done
    int   m_left;
    int   m_pend;
    int   m_final;
    bit   m_en = 0;

    always @(posedge clk) begin
        if (reset || bus.new_game) begin
            foreach (m_cell[i]) m_cell[i] = 0;
            m_count = 0; m_turn = FIRST_PLAYER; m_win = 0; m_err = 0;
            m_phase = 0; m_left = 0; m_pend = 0; m_final = 0;
            m_en = 1;
        end else begin
            m_err = 0;
            if (m_phase == 0 && bus.move_valid) begin
                int p;
                p = int'(bus.move_pos);
                if (p > 8 || m_cell[p] != 0) begin
                    m_err = 1;
                end else begin
                    int k;
                    m_cell[p] = m_turn + 1;
                    m_count++;
                    k = -1;
                    for (int l = 0; l < 8; l++) begin
                        if (k < 0 && m_cell[lines[l][0]] == m_turn + 1 &&
                            m_cell[lines[l][1]] == m_turn + 1 &&
                            m_cell[lines[l][2]] == m_turn + 1) k = l;
                    end
                    if (k >= 0) begin
                        m_left = k + 1; m_pend = m_turn + 1; m_final = 1;
                    end else if (m_count == 9) begin
                        m_left = 8; m_pend = 3; m_final = 1;
                    end else begin
                        m_left = 8; m_final = 0;
                    end
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_final != 0) begin
                        m_win = m_pend; m_phase = 2;
                    end else begin
                        m_turn = 1 - m_turn; m_phase = 0;
                    end
                end
            end
        end
    end

    function automatic logic [8:0] model_board(input int who);
        logic [8:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) if (m_cell[i] == who) b[i] = 1'b1;
        return b;
    endfunction

    always @(negedge clk) begin
        if (m_en) begin
            chk("cyc_board_p1",   bus.board_p1,   model_board(1));
            chk("cyc_board_p2",   bus.board_p2,   model_board(2));
            chk("cyc_turn",       bus.turn,       m_turn);
            chk("cyc_detect_win", bus.detect_win, m_win);
            chk("cyc_move_err",   bus.move_err,   m_err);
            chk("cyc_move_ready", bus.move_ready, m_phase == 0);
            chk("cyc_busy",       bus.busy,       m_phase == 1);
        end
    end

    // Called at a negedge; returns at the negedge right after the handshake edge.
    task automatic do_move(input int pos);
        int n;
        n = 0;
        while (!bus.move_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!bus.move_ready) chk("ready_timeout", 32'd0, 32'd1);
        bus.move_valid = 1'b1;
        bus.move_pos   = 4'(pos);
        @(negedge clk);
        bus.move_valid = 1'b0;
    endtask

    task automatic play(input int seq [$]);
        foreach (seq[i]) do_move(seq[i]);
    endtask

    task automatic pulse_new_game();
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic expect_reset_vals(input string tag);
        chk({tag, "_win"},   bus.detect_win, 2'b00);
        chk({tag, "_ready"}, bus.move_ready, 1'b1);
        chk({tag, "_busy"},  bus.busy,       1'b0);
        chk({tag, "_turn"},  bus.turn,       FIRST_PLAYER);
        chk({tag, "_p1"},    bus.board_p1,   9'd0);
        chk({tag, "_p2"},    bus.board_p2,   9'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.new_game = 1'b0;
        bus.move_valid = 1'b0;
        bus.move_pos = 4'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        expect_reset_vals("reset");
        chk("reset_err", bus.move_err, 1'b0);

        // P1 top row: idx 0 hits one edge after the handshake.
        play('{0, 3, 1, 4});
        do_move(2);
        chk("row_win_at_T", bus.detect_win, 2'b00);
        @(negedge clk);
        chk("row_win_T1", bus.detect_win, 2'b01);
        chk("row_board_p1", bus.board_p1, 9'b000000111);
        bus.move_valid = 1'b1;
        bus.move_pos = 4'd8;
        repeat (3) @(negedge clk);
        bus.move_valid = 1'b0;
        chk("done_ready", bus.move_ready, 1'b0);
        chk("done_board_p1", bus.board_p1, 9'b000000111);
        chk("done_win_hold", bus.detect_win, 2'b01);

        // new_game while in DONE.
        pulse_new_game();
        expect_reset_vals("ng_done");

        // P2 anti-diagonal: only idx 7 matches, result at T+8.
        play('{0, 2, 1, 4, 3});
        do_move(6);
        repeat (7) @(negedge clk);
        chk("anti_T7", bus.detect_win, 2'b00);
        @(negedge clk);
        chk("anti_T8", bus.detect_win, 2'b10);
        chk("anti_board_p2", bus.board_p2, 9'b001010100);
        pulse_new_game();

        // Draw: result 11 at T+8 after the 9th move.
        play('{0, 1, 2, 4, 3, 5, 7, 6});
        chk("draw_pre", bus.detect_win, 2'b00);
        do_move(8);
        repeat (7) @(negedge clk);
        chk("draw_T7", bus.detect_win, 2'b00);
        @(negedge clk);
        chk("draw_T8", bus.detect_win, 2'b11);
        pulse_new_game();

        // Illegal moves: occupied cell, 9 and 15; then a legal move to 5.
        do_move(4);
        do_move(4);
        chk("occ_err", bus.move_err, 1'b1);
        chk("occ_turn", bus.turn, 1'b1);
        chk("occ_p1", bus.board_p1, 9'b000010000);
        @(negedge clk);
        chk("occ_err_gone", bus.move_err, 1'b0);
        do_move(9);
        chk("pos9_err", bus.move_err, 1'b1);
        do_move(15);
        chk("pos15_err", bus.move_err, 1'b1);
        @(negedge clk);
        chk("pos15_err_gone", bus.move_err, 1'b0);
        do_move(5);
        chk("legal5_p2", bus.board_p2, 9'b000100000);
        chk("legal5_busy", bus.busy, 1'b1);
        pulse_new_game();

        // Mid-check reset asserted for edge T+3.
        do_move(0);
        @(negedge clk);
        @(negedge clk);
        pulse_reset();
        expect_reset_vals("midrst");

        // Same with new_game.
        do_move(0);
        @(negedge clk);
        @(negedge clk);
        pulse_new_game();
        expect_reset_vals("midng");

        // Busy/ready window with move_valid held from the handshake onward.
        do_move(4);
        bus.move_valid = 1'b1;
        bus.move_pos = 4'd8;
        for (int i = 0; i < 8; i++) begin
            chk("win_busy", bus.busy, 1'b1);
            chk("win_ready", bus.move_ready, 1'b0);
            if (i < 7) @(negedge clk);
        end
        @(negedge clk);
        chk("t8_ready", bus.move_ready, 1'b1);
        chk("t8_turn", bus.turn, 1'b1);
        chk("t8_p2_empty", bus.board_p2, 9'd0);
        @(negedge clk);
        bus.move_valid = 1'b0;
        chk("t9_p2", bus.board_p2, 9'b100000000);
        chk("t9_busy", bus.busy, 1'b1);
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
